// File: rtl/dfd_CL_axi_pkg.sv
// rtl/dfd_CL_axi_pkg.sv - shared AXI widths, beat size and trace-writer FSM states
// Imported by the trace write packer and its beat buffer.
package dfd_CL_axi_pkg;

  localparam int AddrWidth = 52;
  localparam int DataWidth = 512;
  localparam int StrbWidth = DataWidth / 8;
  localparam int BeatBytes = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } wr_state_e;

  // Byte-enable mask with the lowest nbytes lanes set.
  function automatic logic [StrbWidth-1:0] strb_for_bytes(input int nbytes);
    logic [StrbWidth-1:0] m;
    m = '0;
    for (int i = 0; i < StrbWidth; i++) begin
      if (i < nbytes) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/dfd_tr_beat_buf.sv
// rtl/dfd_tr_beat_buf.sv - Depth-entry beat FIFO with occupancy count
// Head entry is presented combinationally; caller never pushes when full or pops when empty.
module dfd_tr_beat_buf
  import dfd_CL_axi_pkg::*;
#(
  parameter int Depth = 8,
  parameter int Width = DataWidth
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_clr,
  input  logic                       i_push,
  input  logic [Width-1:0]           i_data,
  input  logic                       i_pop,
  output logic [Width-1:0]           o_data,
  output logic [$clog2(Depth+1)-1:0] o_count
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wp;
  logic [PtrW-1:0]  r_rp;
  logic [CntW-1:0]  r_cnt;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wp] <= i_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (i_clr) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wp <= ptr_inc(r_wp);
      if (i_pop)  r_rp <= ptr_inc(r_rp);
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + CntW'(1);
        2'b01:   r_cnt <= r_cnt - CntW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_data  = r_mem[r_rp];
  assign o_count = r_cnt;

endmodule

// File: rtl/dfd_tr_axi_wr_packer.sv
// rtl/dfd_tr_axi_wr_packer.sv - packs trace words into 512-bit beats and writes them as AXI bursts
// Writes into a circular buffer [cfg_base, cfg_limit); bursts never cross the limit or a 4KB page.
module dfd_tr_axi_wr_packer
  import dfd_CL_axi_pkg::*;
#(
  parameter int InWidth  = 128,
  parameter int BurstLen = 8,
  parameter int IdWidth  = 9
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cfg_en,
  input  logic [AddrWidth-1:0] cfg_base,
  input  logic [AddrWidth-1:0] cfg_limit,
  input  logic [IdWidth-1:0]   cfg_id,
  input  logic                 tr_valid,
  output logic                 tr_ready,
  input  logic [InWidth-1:0]   tr_data,
  input  logic                 flush,
  output logic                 aw_valid,
  input  logic                 aw_ready,
  output logic [AddrWidth-1:0] aw_addr,
  output logic [7:0]           aw_len,
  output logic [IdWidth-1:0]   aw_id,
  output logic [2:0]           aw_size,
  output logic [1:0]           aw_burst,
  output logic                 w_valid,
  input  logic                 w_ready,
  output logic [DataWidth-1:0] w_data,
  output logic [StrbWidth-1:0] w_strb,
  output logic                 w_last,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [1:0]           b_resp,
  output logic [AddrWidth-1:0] wr_ptr,
  output logic                 wrapped,
  output logic                 bus_err,
  output logic                 idle
);

  localparam int WordsPerBeat = DataWidth / InWidth;
  localparam int WcW          = $clog2(WordsPerBeat + 1);
  localparam int CntW         = $clog2(BurstLen + 1);
  localparam int RbW          = AddrWidth - 6;

  wr_state_e            r_state, w_state_nxt;
  logic [DataWidth-1:0] r_pack, w_pack_nxt;
  logic [WcW-1:0]       r_wcnt, w_wcnt_nxt;
  logic [StrbWidth-1:0] r_tail_strb;
  logic                 r_flush_pend;
  logic [AddrWidth-1:0] r_wr_ptr, w_ptr_adv;
  logic                 r_wrapped, r_bus_err;
  logic [7:0]           r_beats;
  logic [CntW-1:0]      w_count;
  logic [DataWidth-1:0] w_head;
  logic [RbW-1:0]       w_room_beats;
  logic [6:0]           w_room_4k;
  logic [7:0]           w_target, w_count_nxt;
  logic                 w_in_fill, w_acc, w_do_flush, w_beat_full, w_push, w_pop, w_clr;

  // Beats left before cfg_limit and before the next 4KB page, capped at BurstLen.
  assign w_room_beats = cfg_limit[AddrWidth-1:6] - r_wr_ptr[AddrWidth-1:6];
  assign w_room_4k    = 7'd64 - {1'b0, r_wr_ptr[11:6]};

  always_comb begin
    w_target = 8'(BurstLen);
    if (w_room_beats < RbW'(w_target)) w_target = w_room_beats[7:0];
    if ({1'b0, w_room_4k} < w_target) w_target = {1'b0, w_room_4k};
  end

  assign w_in_fill  = (r_state == ST_FILL) && cfg_en;
  assign tr_ready   = w_in_fill && (8'(w_count) < w_target);
  assign w_acc      = tr_valid && tr_ready;
  assign w_wcnt_nxt = r_wcnt + WcW'(w_acc);

  always_comb begin
    w_pack_nxt = r_pack;
    for (int i = 0; i < WordsPerBeat; i++) begin
      if (w_acc && (r_wcnt == WcW'(i))) w_pack_nxt[i*InWidth +: InWidth] = tr_data;
    end
  end

  // A word accepted in the flush cycle counts as buffered and rides in the flushed beat.
  assign w_do_flush  = w_in_fill && (flush || r_flush_pend) &&
                       ((w_count != '0) || (w_wcnt_nxt != '0));
  assign w_beat_full = (w_wcnt_nxt == WcW'(WordsPerBeat));
  assign w_push      = w_in_fill && (w_beat_full || (w_do_flush && (w_wcnt_nxt != '0)));
  assign w_count_nxt = 8'(w_count) + 8'(w_push);
  assign w_pop       = (r_state == ST_DATA) && w_ready;
  assign w_clr       = (r_state == ST_IDLE) || ((r_state == ST_FILL) && !cfg_en);

  dfd_tr_beat_buf #(
    .Depth(BurstLen),
    .Width(DataWidth)
  ) u_beat_buf (
    .clk    (clk),
    .reset_n(reset_n),
    .i_clr  (w_clr),
    .i_push (w_push),
    .i_data (w_pack_nxt),
    .i_pop  (w_pop),
    .o_data (w_head),
    .o_count(w_count)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (cfg_en) w_state_nxt = ST_FILL;
      ST_FILL: begin
        if (!cfg_en) w_state_nxt = ST_IDLE;
        else if ((w_count_nxt >= w_target) || w_do_flush) w_state_nxt = ST_ADDR;
      end
      ST_ADDR: if (aw_ready) w_state_nxt = ST_DATA;
      ST_DATA: if (w_ready && w_last) w_state_nxt = ST_RESP;
      ST_RESP: if (b_valid) w_state_nxt = cfg_en ? ST_FILL : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pack      <= '0;
      r_wcnt      <= '0;
      r_tail_strb <= '1;
    end else begin
      if (w_clr || w_push) begin
        r_pack <= '0;
        r_wcnt <= '0;
      end else if (w_acc) begin
        r_pack <= w_pack_nxt;
        r_wcnt <= w_wcnt_nxt;
      end
      if (w_push) r_tail_strb <= strb_for_bytes(int'(w_wcnt_nxt) * (InWidth / 8));
    end
  end

  // Flushes outside FILL are remembered and evaluated on the first FILL cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                           r_flush_pend <= 1'b0;
    else if (!cfg_en || r_state == ST_FILL) r_flush_pend <= 1'b0;
    else if (flush)                         r_flush_pend <= 1'b1;
  end

  assign w_ptr_adv = r_wr_ptr + (AddrWidth'(r_beats) << 6);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr  <= '0;
      r_wrapped <= 1'b0;
      r_bus_err <= 1'b0;
      r_beats   <= '0;
    end else begin
      if (r_state == ST_IDLE) r_wr_ptr <= cfg_base;
      if (aw_valid && aw_ready) r_beats <= 8'(w_count);
      if (b_ready && b_valid) begin
        if (w_ptr_adv == cfg_limit) begin
          r_wr_ptr  <= cfg_base;
          r_wrapped <= 1'b1;
        end else begin
          r_wr_ptr <= w_ptr_adv;
        end
        if (b_resp != 2'b00) r_bus_err <= 1'b1;
      end
    end
  end

  assign aw_valid = (r_state == ST_ADDR);
  assign aw_addr  = r_wr_ptr;
  assign aw_len   = 8'(w_count) - 8'd1;
  assign aw_id    = cfg_id;
  assign aw_size  = 3'b110;
  assign aw_burst = 2'b01;
  assign w_valid  = (r_state == ST_DATA);
  assign w_data   = w_head;
  assign w_last   = (r_state == ST_DATA) && (w_count == CntW'(1));
  assign w_strb   = (w_count == CntW'(1)) ? r_tail_strb : '1;
  assign b_ready  = (r_state == ST_RESP);
  assign wr_ptr   = r_wr_ptr;
  assign wrapped  = r_wrapped;
  assign bus_err  = r_bus_err;
  assign idle     = (r_state == ST_IDLE);

endmodule

// File: tb/tb_dfd_tr_axi_wr_packer.sv
// tb/tb_dfd_tr_axi_wr_packer.sv - directed and randomized bench for the trace AXI write packer
// Expected bursts come from a word queue and a circular-buffer pointer model.
module tb_dfd_tr_axi_wr_packer;
  import dfd_CL_axi_pkg::*;

  localparam int InW = 128;
  localparam int BL  = 8;
  localparam int IdW = 9;
  localparam int WPB = DataWidth / InW;

  logic                 clk = 1'b0;
  logic                 reset_n, cfg_en, flush;
  logic [AddrWidth-1:0] cfg_base, cfg_limit;
  logic [IdW-1:0]       cfg_id;
  logic                 tr_valid, tr_ready;
  logic [InW-1:0]       tr_data;
  logic                 aw_valid, aw_ready;
  logic [AddrWidth-1:0] aw_addr;
  logic [7:0]           aw_len;
  logic [IdW-1:0]       aw_id;
  logic [2:0]           aw_size;
  logic [1:0]           aw_burst;
  logic                 w_valid, w_ready, w_last;
  logic [DataWidth-1:0] w_data;
  logic [StrbWidth-1:0] w_strb;
  logic                 b_valid, b_ready;
  logic [1:0]           b_resp;
  logic [AddrWidth-1:0] wr_ptr;
  logic                 wrapped, bus_err, idle;

  dfd_tr_axi_wr_packer #(.InWidth(InW), .BurstLen(BL), .IdWidth(IdW)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_en(cfg_en), .cfg_base(cfg_base), .cfg_limit(cfg_limit),
    .cfg_id(cfg_id), .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_data(tr_data), .flush(flush),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_len(aw_len), .aw_id(aw_id),
    .aw_size(aw_size), .aw_burst(aw_burst), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .w_strb(w_strb), .w_last(w_last), .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp),
    .wr_ptr(wr_ptr), .wrapped(wrapped), .bus_err(bus_err), .idle(idle)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [InW-1:0]  q[$];
  longint unsigned m_ptr, m_base, m_limit;
  bit              m_wrapped, m_err;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_target();
    longint unsigned t, r, k;
    t = BL;
    r = (m_limit - m_ptr) / 64;
    if (r < t) t = r;
    k = (4096 - (m_ptr % 4096)) / 64;
    if (k < t) t = k;
    return int'(t);
  endfunction

  task automatic push_word(input logic [InW-1:0] d, input bit fl);
    int n;
    n = 0;
    @(negedge clk);
    while (!tr_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("tr_ready_wait", tr_ready, 1);
    tr_valid = 1'b1;
    tr_data  = d;
    flush    = fl;
    @(posedge clk);
    #1;
    tr_valid = 1'b0;
    flush    = 1'b0;
    q.push_back(d);
  endtask

  task automatic push_n(input int n, input bit fl_last);
    for (int i = 0; i < n; i++)
      push_word({$urandom, $urandom, $urandom, $urandom}, fl_last && (i == n - 1));
  endtask

  task automatic pulse_flush();
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic slave_burst(input int nw, input logic [1:0] resp, input bit stall, input bit fl_in_data);
    int beats, n, idx;
    logic [InW-1:0] bw[$];
    logic [DataWidth-1:0] ed, sd;
    logic [StrbWidth-1:0] es;
    logic [AddrWidth-1:0] sa;
    logic [7:0] sl;
    bit ok;
    beats = (nw + WPB - 1) / WPB;
    for (int i = 0; i < nw; i++) bw.push_back(q.pop_front());
    n = 0;
    @(negedge clk);
    while (!aw_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("aw_valid", aw_valid, 1);
    check("aw_addr", aw_addr, m_ptr[AddrWidth-1:0]);
    check("aw_len", aw_len, beats - 1);
    check("aw_id", aw_id, cfg_id);
    check("aw_w_exclusive", w_valid, 0);
    if (stall) begin
      ok = 1;
      sa = aw_addr;
      sl = aw_len;
      repeat (20) begin
        @(negedge clk);
        if (!aw_valid || aw_addr !== sa || aw_len !== sl || tr_ready || w_valid) ok = 0;
      end
      check("aw_stall_stable", ok, 1);
    end
    aw_ready = 1'b1;
    @(posedge clk);
    #1;
    aw_ready = 1'b0;
    for (int b = 0; b < beats; b++) begin
      ed = '0;
      es = '0;
      for (int k = 0; k < WPB; k++) begin
        idx = b * WPB + k;
        if (idx < nw) begin
          ed[k*InW +: InW] = bw[idx];
          es[k*(InW/8) +: (InW/8)] = '1;
        end
      end
      n = 0;
      @(negedge clk);
      while (!w_valid && n < 300) begin
        @(negedge clk);
        n++;
      end
      check("w_valid", w_valid, 1);
      check("w_aw_exclusive", aw_valid, 0);
      if (stall && b == 0) begin
        ok = 1;
        sd = w_data;
        repeat (20) begin
          @(negedge clk);
          if (!w_valid || w_data !== sd || w_strb !== es || tr_ready || aw_valid) ok = 0;
        end
        check("w_stall_stable", ok, 1);
      end
      check("w_data", w_data, ed);
      check("w_strb", w_strb, es);
      check("w_last", w_last, (b == beats - 1));
      w_ready = 1'b1;
      flush   = fl_in_data && (b == 0);
      @(posedge clk);
      #1;
      w_ready = 1'b0;
      flush   = 1'b0;
    end
    n = 0;
    @(negedge clk);
    while (!b_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("b_ready", b_ready, 1);
    b_valid = 1'b1;
    b_resp  = resp;
    @(posedge clk);
    #1;
    b_valid = 1'b0;
    b_resp  = 2'b00;
    m_ptr = m_ptr + longint'(beats) * 64;
    if (m_ptr == m_limit) begin
      m_ptr     = m_base;
      m_wrapped = 1;
    end
    if (resp != 2'b00) m_err = 1;
    @(negedge clk);
    check("wr_ptr", wr_ptr, m_ptr[AddrWidth-1:0]);
    check("wrapped", wrapped, m_wrapped);
    check("bus_err", bus_err, m_err);
  endtask

  task automatic full_burst(input logic [1:0] resp, input bit stall, input bit fl_in_data);
    int nw;
    nw = m_target() * WPB;
    push_n(nw, 0);
    slave_burst(nw, resp, stall, fl_in_data);
  endtask

  initial begin
    int nw;
    reset_n = 0; cfg_en = 0; flush = 0; tr_valid = 0; tr_data = '0;
    aw_ready = 0; w_ready = 0; b_valid = 0; b_resp = 2'b00;
    cfg_base = 52'h10000; cfg_limit = 52'h20000; cfg_id = 9'h1A5;
    m_base = 64'h10000; m_limit = 64'h20000; m_ptr = m_base; m_wrapped = 0; m_err = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_aw_valid", aw_valid, 0);
    check("rst_w_valid", w_valid, 0);
    check("rst_tr_ready", tr_ready, 0);
    check("rst_b_ready", b_ready, 0);
    check("rst_wr_ptr", wr_ptr, 0);
    check("rst_flags", {wrapped, bus_err}, 0);
    check("rst_idle", idle, 1);
    @(negedge clk);
    reset_n = 1;
    cfg_en  = 1;
    @(posedge clk);
    #1;
    check("start_wr_ptr", wr_ptr, 52'h10000);
    check("start_idle", idle, 0);
    check("aw_size_burst", {aw_size, aw_burst}, {3'b110, 2'b01});

    // 32 words -> one full 8-beat burst
    push_n(32, 0);
    slave_burst(32, 2'b00, 0, 0);
    check("ptr_after_first", wr_ptr, 52'h10200);

    // 6 words then flush -> 2 beats, second half-strobed
    push_n(6, 0);
    pulse_flush();
    slave_burst(6, 2'b00, 0, 0);

    // flush with an empty buffer does nothing
    pulse_flush();
    repeat (3) @(posedge clk);
    #1;
    check("empty_flush_no_aw", aw_valid, 0);
    check("empty_flush_tr_ready", tr_ready, 1);

    // word and flush in the same cycle
    push_n(5, 1);
    slave_burst(5, 2'b00, 0, 0);

    // SLVERR on the middle burst
    full_burst(2'b00, 0, 0);
    full_burst(2'b10, 0, 0);
    check("bus_err_set", bus_err, 1);
    full_burst(2'b00, 0, 0);

    // back-pressure on AW and W, with a flush pulse landing in DATA
    full_burst(2'b00, 1, 1);
    full_burst(2'b00, 0, 0);

    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        full_burst(2'b00, 0, 0);
      end else begin
        nw = $urandom_range(1, m_target() * WPB - 1);
        push_n(nw, 0);
        pulse_flush();
        slave_burst(nw, 2'b00, 0, 0);
      end
    end

    // reprogram a 4KB ring and run it up to the wrap
    @(negedge clk);
    cfg_en = 0;
    repeat (2) @(posedge clk);
    #1;
    check("disabled_idle", idle, 1);
    cfg_base = 52'h1000; cfg_limit = 52'h2000;
    m_base = 64'h1000; m_limit = 64'h2000; m_ptr = m_base;
    @(negedge clk);
    cfg_en = 1;
    @(posedge clk);
    #1;
    check("ring_wr_ptr", wr_ptr, 52'h1000);
    while (m_ptr != 64'h1E00) full_burst(2'b00, 0, 0);
    push_n(28, 0);
    pulse_flush();
    slave_burst(28, 2'b00, 0, 0);
    check("ring_at_1fc0", wr_ptr, 52'h1FC0);
    nw = m_target() * WPB;
    check("ring_last_target_words", nw, WPB);
    push_n(nw, 0);
    slave_burst(nw, 2'b00, 0, 0);
    check("ring_wrapped_ptr", wr_ptr, 52'h1000);
    check("ring_wrapped_flag", wrapped, 1);

    // reset while in DATA
    push_n(m_target() * WPB, 0);
    @(negedge clk);
    while (!aw_valid) @(negedge clk);
    aw_ready = 1'b1;
    @(posedge clk);
    #1;
    aw_ready = 1'b0;
    @(negedge clk);
    check("pre_reset_w_valid", w_valid, 1);
    reset_n = 0;
    #1;
    check("mid_rst_valids", {aw_valid, w_valid, tr_ready, b_ready}, 0);
    check("mid_rst_wr_ptr", wr_ptr, 0);
    check("mid_rst_flags", {wrapped, bus_err}, 0);
    check("mid_rst_idle", idle, 1);
    q.delete();
    m_ptr = m_base; m_wrapped = 0; m_err = 0;
    @(negedge clk);
    reset_n = 1;
    @(posedge clk);
    #1;
    check("post_rst_wr_ptr", wr_ptr, 52'h1000);
    full_burst(2'b00, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
